// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU.
// Covers datapath width, flag bit positions, opcode constants and opcode decoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 5;

  // Bit positions inside the Flags vector
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  // Opcode constants (register form, then immediate form)
  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDI   = 8'h50;
  localparam logic [7:0] OP_ADDU   = 8'h06;
  localparam logic [7:0] OP_ADDUI  = 8'h60;
  localparam logic [7:0] OP_ADDC   = 8'h07;
  localparam logic [7:0] OP_ADDCI  = 8'h70;
  localparam logic [7:0] OP_ADDCU  = 8'h04;
  localparam logic [7:0] OP_ADDCUI = 8'h40;
  localparam logic [7:0] OP_SUB    = 8'h09;
  localparam logic [7:0] OP_SUBI   = 8'h90;
  localparam logic [7:0] OP_CMP    = 8'h0B;
  localparam logic [7:0] OP_CMPI   = 8'hB0;
  localparam logic [7:0] OP_CMPU   = 8'h08;
  localparam logic [7:0] OP_CMPUI  = 8'h0C;
  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_NOT    = 8'h0F;
  localparam logic [7:0] OP_LSH    = 8'h84;
  localparam logic [7:0] OP_LSHI   = 8'h80;
  localparam logic [7:0] OP_RSH    = 8'h85;
  localparam logic [7:0] OP_RSHI   = 8'h81;
  localparam logic [7:0] OP_ALSH   = 8'h86;
  localparam logic [7:0] OP_ARSH   = 8'h87;

  // Operation class after decode; immediate and register forms collapse together
  typedef enum logic [3:0] {
    CLS_ADD_S,
    CLS_ADD_U,
    CLS_SUB,
    CLS_CMP,
    CLS_CMPU,
    CLS_AND,
    CLS_OR,
    CLS_XOR,
    CLS_NOT,
    CLS_LSH,
    CLS_RSH,
    CLS_ARSH,
    CLS_BAD
  } op_class_e;

  function automatic op_class_e decode_op(input logic [7:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI:       return CLS_ADD_S;
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI:   return CLS_ADD_U;
      OP_SUB, OP_SUBI:                          return CLS_SUB;
      OP_CMP, OP_CMPI:                          return CLS_CMP;
      OP_CMPU, OP_CMPUI:                        return CLS_CMPU;
      OP_AND:                                   return CLS_AND;
      OP_OR:                                    return CLS_OR;
      OP_XOR:                                   return CLS_XOR;
      OP_NOT:                                   return CLS_NOT;
      OP_LSH, OP_LSHI, OP_ALSH:                 return CLS_LSH;
      OP_RSH, OP_RSHI:                          return CLS_RSH;
      OP_ARSH:                                  return CLS_ARSH;
      default:                                  return CLS_BAD;
    endcase
  endfunction

  // Only the ADDC/ADDCU family consumes carryIn
  function automatic logic uses_carry(input logic [7:0] op);
    return (op == OP_ADDC) || (op == OP_ADDCI) ||
           (op == OP_ADDCU) || (op == OP_ADDCUI);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between an ALU user (master) and the ALU (slave).
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [7:0]        Opcode;
  logic              carryIn;
  logic [DATA_W-1:0] C;
  logic [FLAG_W-1:0] Flags;

  modport master (
    output A, B, Opcode, carryIn,
    input  C, Flags
  );

  modport slave (
    input  A, B, Opcode, carryIn,
    output C, Flags
  );

endinterface

// File: rtl/alu_addsub.sv
// Shared adder for add, subtract and compare.
// Subtraction is a + ~b + 1, so borrow is the inverted carry-out.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [DATA_W:0]   sum,
  output logic              ovf,
  output logic              borrow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] b_eff;
  logic              cin_eff;

  // 17-bit sum plus signed-overflow and borrow detection on the effective operands
  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? 1'b1 : cin;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_eff};
    ovf     = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    borrow  = sub & ~sum[DATA_W];
  end

endmodule

// File: rtl/alu.sv
// 16-bit ALU: a combinational next-state block followed by one output register.
// Logic, shift and undefined opcodes hold the previous flags.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  alu_if.slave  bus
);

  op_class_e                cls;
  logic                     sub_mode;
  logic                     cin_mode;
  logic [DATA_W:0]          sum;
  logic                     ovf;
  logic                     borrow;
  logic [DATA_W-1:0]        res;
  logic [3:0]               shamt;
  logic signed [DATA_W-1:0] a_s;

  logic [DATA_W-1:0] c_d, c_q;
  logic [FLAG_W-1:0] flags_d, flags_q;

  // Decode the opcode and set up the shared adder controls
  always_comb begin
    cls      = decode_op(bus.Opcode);
    sub_mode = (cls == CLS_SUB) || (cls == CLS_CMP) || (cls == CLS_CMPU);
    cin_mode = uses_carry(bus.Opcode) ? bus.carryIn : 1'b0;
    shamt    = bus.B[3:0];
    a_s      = bus.A;
  end

  alu_addsub u_addsub (
    .a      (bus.A),
    .b      (bus.B),
    .sub    (sub_mode),
    .cin    (cin_mode),
    .sum    (sum),
    .ovf    (ovf),
    .borrow (borrow)
  );

  assign res = sum[DATA_W-1:0];

  // Next result and flags; flags default to holding their value
  always_comb begin
    c_d     = '0;
    flags_d = flags_q;
    case (cls)
      CLS_ADD_S: begin
        c_d             = res;
        flags_d         = '0;
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_C] = sum[DATA_W];
        flags_d[FLAG_O] = ovf;
        flags_d[FLAG_N] = res[DATA_W-1];
      end
      CLS_ADD_U: begin
        c_d             = res;
        flags_d         = '0;
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_C] = sum[DATA_W];
      end
      CLS_SUB: begin
        c_d             = res;
        flags_d         = '0;
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_C] = borrow;
        flags_d[FLAG_O] = ovf;
        flags_d[FLAG_L] = borrow;
        flags_d[FLAG_N] = res[DATA_W-1];
      end
      CLS_CMP: begin
        // Signed less-than is the sign of A-B corrected by overflow
        flags_d         = '0;
        flags_d[FLAG_Z] = (bus.A == bus.B);
        flags_d[FLAG_L] = borrow;
        flags_d[FLAG_N] = res[DATA_W-1] ^ ovf;
      end
      CLS_CMPU: begin
        flags_d         = '0;
        flags_d[FLAG_Z] = (bus.A == bus.B);
        flags_d[FLAG_L] = borrow;
      end
      CLS_AND:  c_d = bus.A & bus.B;
      CLS_OR:   c_d = bus.A | bus.B;
      CLS_XOR:  c_d = bus.A ^ bus.B;
      CLS_NOT:  c_d = ~bus.A;
      CLS_LSH:  c_d = bus.A << shamt;
      CLS_RSH:  c_d = bus.A >> shamt;
      CLS_ARSH: c_d = a_s >>> shamt;
      default:  c_d = '0;
    endcase
  end

  // Output register; reset clears result and flags immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign bus.C     = c_q;
  assign bus.Flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for the 16-bit ALU, plus reset sequences.
module tb_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_c;
    logic [4:0]  exp_f;   // Z C O L N
  } vec_t;

  localparam int NVEC = 28;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NVEC];

  alu_if bus ();

  alu u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin);
    bus.Opcode  = op;
    bus.A       = a;
    bus.B       = b;
    bus.carryIn = cin;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Applied in order; flags of logic/shift/undefined ops are the previous row's flags
    vecs[0]  = '{8'h05, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00101}; // ADD overflow
    vecs[1]  = '{8'h05, 16'hFFFF, 16'h8000, 1'b0, 16'h7FFF, 5'b01100}; // ADD carry+ovf
    vecs[2]  = '{8'h07, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b00101}; // ADDC
    vecs[3]  = '{8'h09, 16'hFFFB, 16'hFFFB, 1'b0, 16'h0000, 5'b10000}; // SUB equal
    vecs[4]  = '{8'h0B, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b00001}; // CMP -1 vs 1
    vecs[5]  = '{8'h87, 16'h8000, 16'h0003, 1'b0, 16'hF000, 5'b00001}; // ARSH
    vecs[6]  = '{8'h01, 16'h0F0F, 16'h00FF, 1'b0, 16'h000F, 5'b00001}; // AND
    vecs[7]  = '{8'h02, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 5'b00001}; // OR
    vecs[8]  = '{8'h03, 16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 5'b00001}; // XOR
    vecs[9]  = '{8'h0F, 16'h1234, 16'h0000, 1'b0, 16'hEDCB, 5'b00001}; // NOT
    vecs[10] = '{8'h06, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b11000}; // ADDU wrap
    vecs[11] = '{8'h80, 16'h0001, 16'hFFF4, 1'b0, 16'h0010, 5'b11000}; // LSHI neg B
    vecs[12] = '{8'h85, 16'h8000, 16'h000F, 1'b0, 16'h0001, 5'b11000}; // RSH by 15
    vecs[13] = '{8'h86, 16'hC001, 16'h0001, 1'b0, 16'h8002, 5'b11000}; // ALSH
    vecs[14] = '{8'hFF, 16'h1234, 16'h0001, 1'b1, 16'h0000, 5'b11000}; // undefined
    vecs[15] = '{8'h90, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 5'b01011}; // SUBI borrow
    vecs[16] = '{8'h09, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b00100}; // SUB ovf
    vecs[17] = '{8'h08, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 5'b00010}; // CMPU
    vecs[18] = '{8'hB0, 16'h1234, 16'h1234, 1'b0, 16'h0000, 5'b10000}; // CMPI equal
    vecs[19] = '{8'h04, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b11000}; // ADDCU
    vecs[20] = '{8'h05, 16'h0002, 16'h0003, 1'b1, 16'h0005, 5'b00000}; // ADD ignores cin
    vecs[21] = '{8'h50, 16'h8000, 16'h8000, 1'b0, 16'h0000, 5'b11100}; // ADDI
    vecs[22] = '{8'h70, 16'h0001, 16'h0001, 1'b0, 16'h0002, 5'b00000}; // ADDCI cin=0
    vecs[23] = '{8'h0C, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b00000}; // CMPUI
    vecs[24] = '{8'h81, 16'hFFFF, 16'h0010, 1'b0, 16'hFFFF, 5'b00000}; // RSHI shamt 0
    vecs[25] = '{8'h60, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b00000}; // ADDUI
    vecs[26] = '{8'h40, 16'h8000, 16'h8000, 1'b0, 16'h0000, 5'b11000}; // ADDCUI
    vecs[27] = '{8'h87, 16'h4000, 16'h0002, 1'b0, 16'h1000, 5'b11000}; // ARSH positive

    // Reset state, visible without any clock edge
    reset_n = 1'b0;
    drive(8'h05, 16'h1111, 16'h2222, 1'b0);
    #1;
    check("reset_C", bus.C, 16'h0000);
    check("reset_Flags", {11'd0, bus.Flags}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold_C", bus.C, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_no_edge_C", bus.C, 16'h0000);

    // Table-driven vectors: drive on falling edge, sample after rising edge
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_C", i), bus.C, vecs[i].exp_c);
      check($sformatf("vec%0d_Flags", i), {11'd0, bus.Flags}, {11'd0, vecs[i].exp_f});
    end

    // Mid-stream reset: load a nonzero result, then assert reset between edges
    @(negedge clk);
    drive(8'h09, 16'h0001, 16'h0002, 1'b0);   // SUB -> FFFF, 01011
    @(posedge clk);
    #1;
    check("pre_reset_C", bus.C, 16'hFFFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_C", bus.C, 16'h0000);
    check("async_reset_Flags", {11'd0, bus.Flags}, 16'h0000);
    @(negedge clk);
    drive(8'h05, 16'h0002, 16'h0003, 1'b0);
    @(posedge clk);
    #1;
    check("held_reset_C", bus.C, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_sync_C", bus.C, 16'h0000);
    @(posedge clk);
    #1;
    check("first_after_release_C", bus.C, 16'h0005);
    check("first_after_release_Flags", {11'd0, bus.Flags}, 16'h0000);

    // Flags persist across a run of non-flag ops following a compare
    @(negedge clk);
    drive(8'h0B, 16'h0001, 16'hFFFF, 1'b0);   // CMP 1 vs -1: L=1, N=0
    @(posedge clk);
    #1;
    check("seq_cmp_Flags", {11'd0, bus.Flags}, 16'h0002);
    @(negedge clk);
    drive(8'h84, 16'h0003, 16'h0002, 1'b1);   // LSH
    @(posedge clk);
    @(negedge clk);
    drive(8'h55, 16'h0003, 16'h0002, 1'b1);   // undefined
    @(posedge clk);
    #1;
    check("seq_undef_C", bus.C, 16'h0000);
    check("seq_undef_Flags", {11'd0, bus.Flags}, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 A  input  16  operand A, two's complement; also the shift source.
REQ-004 B  input  16  operand B or immediate; B[3:0] is the shift amount.
REQ-005 Opcode  input  8  operation select.
REQ-006 carryIn  input  1  carry-in for the ADDC family.
REQ-007 C  output  16  registered result.
REQ-008 Flags  output  5  registered flags: [4] Z, [3] C (carry), [2] O (overflow), [1] L (unsigned less), [0] N.

Function
REQ-009 C and Flags SHALL update on every rising clk edge from the current inputs, so latency is 1 cycle; there is no handshake.
REQ-010 Immediate opcodes SHALL behave exactly like their register forms, with B carrying the immediate.
REQ-011 Opcodes SHALL be decoded as follows:
- ADD 05, ADDI 50: A+B.
- ADDU 06, ADDUI 60: A+B.
- ADDC 07, ADDCI 70: A+B+carryIn.
- ADDCU 04, ADDCUI 40: A+B+carryIn.
- SUB 09, SUBI 90: A-B.
- CMP 0B, CMPI B0: signed compare.
- CMPU 08, CMPUI 0C: unsigned compare.
- AND 01, OR 02, XOR 03, NOT 0F (~A).
- LSH 84, LSHI 80: logical left.
- RSH 85, RSHI 81: logical right.
- ALSH 86: arithmetic left, same as logical left.
- ARSH 87: sign-filling right.
REQ-012 All results SHALL be 16-bit, with wrap-around modulo 2^16.
REQ-013 Signed adds (ADD, ADDC and immediates) SHALL set:
- C = bit 16 of the 17-bit unsigned sum.
- O = signed overflow (operands of equal sign, result of the opposite sign).
- N = result[15].
- Z = (result==0).
- L = 0.
REQ-014 Unsigned adds (ADDU, ADDCU and immediates) SHALL set C = carry-out, Z = (result==0), and clear O, N and L.
REQ-015 SUB SHALL set:
- C = borrow, i.e. unsigned A<B.
- O = signed overflow of A-B.
- N = result[15].
- Z = (result==0).
- L = unsigned A<B.
REQ-016 CMP SHALL set Z = (A==B), N = signed A<B, L = unsigned A<B, and clear C and O; C SHALL be 0.
REQ-017 CMPU SHALL behave like CMP except that N is cleared.
REQ-018 Logic and shift ops SHALL leave Flags unchanged.
REQ-019 The shift amount SHALL be B[3:0], range 0..15; B[15:4] is ignored, so a negative B uses its low nibble.
REQ-020 An undefined opcode SHALL load C=0 and leave Flags unchanged.
REQ-021 carryIn SHALL affect only the ADDC/ADDCU family.

Reset
REQ-022 reset_n low SHALL immediately force C=16'h0000 and Flags=5'b00000, independent of clk.
REQ-023 Release of reset SHALL be sampled synchronously; the first update occurs on the first rising clk edge with reset_n high.
REQ-024 Reset asserted mid-operation SHALL discard any pending result.

Structure
REQ-025 Opcode constants and flag bit indices SHALL be defined in a shared package, alu_pkg.
REQ-026 The design SHALL be a combinational next-state block followed by one output register stage.
REQ-027 The add/subtract path SHALL be one sub-module, alu_addsub, that produces the 17-bit sum, overflow and borrow.

Verification
Flags below are written Z C O L N.
REQ-028 ADD, A=32767, B=1 -> C=0x8000, Flags=00101.
REQ-029 ADD, A=-1, B=-32768 -> C=0x7FFF, Flags=01100.
REQ-030 ADDC, carryIn=1, A=32767, B=0 -> C=0x8000, Flags=00101.
REQ-031 SUB, A=-5, B=-5 -> C=0, Flags=10000.
REQ-032 CMP, A=-1, B=1 -> Flags=00001; then ARSH, A=0x8000, B=3 -> C=0xF000 with Flags still 00001.
REQ-033 Assert reset_n low mid-stream -> C=0 and Flags=0 before the next clk edge.
